// File: rtl/mux64_rr_arbiter.sv
// mux64_rr_arbiter: round-robin arbiter feeding a registered 4:1 64-bit
// result path, with bounded lock bursts and a one-entry output stage.
//
// Ports:
//   Clk, Reset        rising-edge clock, synchronous active-high reset
//   ReqValid[3:0]     requester i offers a word (0=A .. 3=D)
//   ReqLock[3:0]      requester i wants to keep the grant after this beat
//   InA..InD          requester words
//   ReqReady[3:0]     one-hot accept strobe (combinational)
//   OutData, Sel      registered winning word and its select code
//   OutValid          OutData holds an unconsumed word
//   OutReady          consumer takes OutData this cycle
//   Locked            arbiter is in its locked state
module mux64_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [3:0]            ReqValid,
    input  logic [3:0]            ReqLock,
    input  logic [DATA_WIDTH-1:0] InA,
    input  logic [DATA_WIDTH-1:0] InB,
    input  logic [DATA_WIDTH-1:0] InC,
    input  logic [DATA_WIDTH-1:0] InD,
    output logic [3:0]            ReqReady,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [1:0]            Sel,
    output logic                  Locked
);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Beat count at which the current transfer is the last one allowed.
    localparam logic [7:0] LockLast = 8'(LOCK_MAX - 1);

    state_t                  state;
    logic [1:0]              ptr;
    logic [1:0]              owner;
    logic [7:0]              beatCnt;

    logic                    slotFree;
    logic [1:0]              arbIdx;
    logic                    arbFound;
    logic [1:0]              winIdx;
    logic                    hasWin;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   winData;

    assign slotFree = !OutValid || OutReady;

    // Rotating priority scan starting at ptr.
    always_comb begin
        arbIdx   = ptr;
        arbFound = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!arbFound && ReqValid[ptr + 2'(k)]) begin
                arbIdx   = ptr + 2'(k);
                arbFound = 1'b1;
            end
        end
    end

    // While locked only the owner may move; everyone else waits.
    always_comb begin
        winIdx = arbIdx;
        hasWin = arbFound;
        if (state == LOCKED) begin
            winIdx = owner;
            hasWin = ReqValid[owner];
        end
    end

    assign xfer = hasWin && slotFree && !Reset;

    always_comb begin
        ReqReady = 4'b0000;
        if (xfer) begin
            ReqReady[winIdx] = 1'b1;
        end
    end

    always_comb begin
        winData = InA;
        unique case (winIdx)
            2'd0: winData = InA;
            2'd1: winData = InB;
            2'd2: winData = InC;
            2'd3: winData = InD;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ARB;
            ptr      <= 2'd0;
            owner    <= 2'd0;
            beatCnt  <= 8'd0;
            OutData  <= '0;
            OutValid <= 1'b0;
            Sel      <= 2'd0;
        end else begin
            if (xfer) begin
                OutData  <= winData;
                Sel      <= winIdx;
                OutValid <= 1'b1;
                unique case (state)
                    ARB: begin
                        if (ReqLock[winIdx]) begin
                            state   <= LOCKED;
                            owner   <= winIdx;
                            beatCnt <= 8'd1;
                        end else begin
                            ptr <= winIdx + 2'd1;
                        end
                    end
                    LOCKED: begin
                        beatCnt <= beatCnt + 8'd1;
                        // Final beat, or burst hit its length limit.
                        if (!ReqLock[owner] || beatCnt == LockLast) begin
                            state <= ARB;
                            ptr   <= owner + 2'd1;
                        end
                    end
                endcase
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end

    assign Locked = (state == LOCKED);

endmodule

// File: tb/tb_mux64_rr_arbiter.sv
// tb_mux64_rr_arbiter: directed checks of reset, rotation, back-pressure,
// lock bursts, forced release and reset during a burst.
module tb_mux64_rr_arbiter;

    logic        Clk;
    logic        Reset;
    logic [3:0]  ReqValid;
    logic [3:0]  ReqLock;
    logic [63:0] InA, InB, InC, InD;
    logic [3:0]  ReqReady;
    logic [63:0] OutData;
    logic        OutValid;
    logic        OutReady;
    logic [1:0]  Sel;
    logic        Locked;

    int total = 0;
    int bad   = 0;

    logic [63:0] words [4];

    mux64_rr_arbiter #(.DATA_WIDTH(64), .LOCK_MAX(8)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .ReqValid(ReqValid),
        .ReqLock(ReqLock),
        .InA(InA),
        .InB(InB),
        .InC(InC),
        .InD(InD),
        .ReqReady(ReqReady),
        .OutData(OutData),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .Sel(Sel),
        .Locked(Locked)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        words[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        words[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        words[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        words[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        InA = words[0];
        InB = words[1];
        InC = words[2];
        InD = words[3];

        // Reset with everyone requesting
        Reset    = 1'b1;
        ReqValid = 4'b1111;
        ReqLock  = 4'b0000;
        OutReady = 1'b1;
        #1;
        chk("rst_ready0", 64'(ReqReady), 64'h0);
        tick();
        chk("rst_ready1", 64'(ReqReady), 64'h0);
        tick();
        chk("rst_ready2", 64'(ReqReady), 64'h0);
        chk("rst_valid", 64'(OutValid), 64'h0);
        chk("rst_sel", 64'(Sel), 64'h0);
        chk("rst_locked", 64'(Locked), 64'h0);
        chk("rst_data", OutData, 64'h0);
        Reset = 1'b0;
        #1;
        chk("first_grant", 64'(ReqReady), 64'h1);

        // Rotation 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rot_sel", 64'(Sel), 64'(i % 4));
            chk("rot_data", OutData, words[i % 4]);
            chk("rot_valid", 64'(OutValid), 64'h1);
            chk("rot_ready", 64'(ReqReady), 64'(4'b0001 << ((i + 1) % 4)));
        end
        tick();
        chk("pre_bp_sel1", 64'(Sel), 64'h1);
        tick();
        chk("pre_bp_sel2", 64'(Sel), 64'h2);

        // Back-pressure holding word C
        OutReady = 1'b0;
        #1;
        chk("bp_ready", 64'(ReqReady), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_sel", 64'(Sel), 64'h2);
            chk("bp_data", OutData, words[2]);
            chk("bp_valid", 64'(OutValid), 64'h1);
            chk("bp_ready", 64'(ReqReady), 64'h0);
        end
        OutReady = 1'b1;
        #1;
        chk("bp_release", 64'(ReqReady), 64'h8);
        tick();
        chk("bp_next_sel", 64'(Sel), 64'h3);
        chk("bp_next_data", OutData, words[3]);

        // Lock burst by 1, requester 3 waiting
        ReqValid = 4'b1010;
        for (int b = 1; b <= 4; b++) begin
            ReqLock = (b < 4) ? 4'b0010 : 4'b0000;
            #1;
            chk("lk_ready", 64'(ReqReady), 64'h2);
            tick();
            chk("lk_sel", 64'(Sel), 64'h1);
            chk("lk_locked", 64'(Locked), 64'(b < 4));
        end
        #1;
        chk("lk_next_ready", 64'(ReqReady), 64'h8);
        tick();
        chk("lk_next_sel", 64'(Sel), 64'h3);

        // Forced release after 8 beats
        ReqValid = 4'b0101;
        ReqLock  = 4'b0001;
        for (int b = 1; b <= 8; b++) begin
            #1;
            chk("fr_ready", 64'(ReqReady), 64'h1);
            tick();
            chk("fr_sel", 64'(Sel), 64'h0);
            chk("fr_locked", 64'(Locked), 64'(b < 8));
        end
        #1;
        chk("fr_next_ready", 64'(ReqReady), 64'h4);
        tick();
        chk("fr_next_sel", 64'(Sel), 64'h2);
        chk("fr_next_data", OutData, words[2]);

        // Reset during beat 3 of a burst by 1
        ReqValid = 4'b0010;
        ReqLock  = 4'b0010;
        tick();
        chk("rm_locked1", 64'(Locked), 64'h1);
        tick();
        chk("rm_sel2", 64'(Sel), 64'h1);
        Reset = 1'b1;
        #1;
        chk("rm_ready", 64'(ReqReady), 64'h0);
        tick();
        chk("rm_locked", 64'(Locked), 64'h0);
        chk("rm_valid", 64'(OutValid), 64'h0);
        chk("rm_sel", 64'(Sel), 64'h0);
        Reset    = 1'b0;
        ReqValid = 4'b1111;
        ReqLock  = 4'b0000;
        #1;
        chk("rm_restart", 64'(ReqReady), 64'h1);
        tick();
        chk("rm_restart_sel", 64'(Sel), 64'h0);
        chk("rm_restart_data", OutData, words[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
